// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short press, long press and double click.
// Optional auto-repeat of long_tick while held: define BUTTON_AUTO_REPEAT_EN.
module button_press_classifier #(
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned LONG_CNT   = 50000000,
    parameter int unsigned GAP_CNT    = 25000000,
    parameter int unsigned REPEAT_CNT = 10000000
) (
    input  logic       clk_amisha,
    input  logic       reset_amisha,
    input  logic       db_level_in,
    input  logic       db_tick_in,
    output logic       short_tick,
    output logic       long_tick,
    output logic       double_tick,
    output logic       hold_level,
    output logic [7:0] event_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        WAIT_GAP  = 3'd2,
        SECOND    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             short_next;
    logic             long_next;
    logic             double_next;
    logic             hold_next;
    logic             any_event;

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state       <= IDLE;
            cnt         <= '0;
            short_tick  <= 1'b0;
            long_tick   <= 1'b0;
            double_tick <= 1'b0;
            hold_level  <= 1'b0;
            event_count <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            short_tick  <= short_next;
            long_tick   <= long_next;
            double_tick <= double_next;
            hold_level  <= hold_next;
            if (any_event)
                event_count <= event_count + 8'd1;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;

        case (state)
            IDLE: begin
                if (db_tick_in)
                    state_next = PRESSED;
            end
            PRESSED: begin
                if (!db_level_in) begin
                    state_next = WAIT_GAP;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG_HOLD;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            LONG_HOLD: begin
                if (!db_level_in) begin
                    state_next = IDLE;
                end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (cnt == REPEAT_LAST) begin
                        cnt_next  = '0;
                        long_next = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
`endif
                end
            end
            WAIT_GAP: begin
                // a second press on the expiry cycle still counts as a double click
                if (db_tick_in) begin
                    state_next = SECOND;
                end else if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SECOND: begin
                if (!db_level_in) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end else if (cnt != '1) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // every state change, including recovery from an illegal code, restarts timing
        if (state_next != state)
            cnt_next = '0;
    end

    assign hold_next = (state_next == LONG_HOLD);
    assign any_event = short_next | long_next | double_next;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_CNT=8, GAP_CNT=6, REPEAT_CNT=4.
module tb_button_press_classifier;

    logic       clk_amisha = 1'b0;
    logic       reset_amisha;
    logic       db_level_in;
    logic       db_tick_in;
    logic       short_tick;
    logic       long_tick;
    logic       double_tick;
    logic       hold_level;
    logic [7:0] event_count;

    button_press_classifier #(
        .CNT_W(8),
        .LONG_CNT(8),
        .GAP_CNT(6),
        .REPEAT_CNT(4)
    ) dut (
        .clk_amisha(clk_amisha),
        .reset_amisha(reset_amisha),
        .db_level_in(db_level_in),
        .db_tick_in(db_tick_in),
        .short_tick(short_tick),
        .long_tick(long_tick),
        .double_tick(double_tick),
        .hold_level(hold_level),
        .event_count(event_count)
    );

    always #5 clk_amisha = ~clk_amisha;

    int compared   = 0;
    int mismatched = 0;

    int cyc = 0;
    int n_short, n_long, n_double, n_multi, n_cnt_err;
    int t_short_first, t_short_last, t_long_first, t_long_last, t_double;
    int t_hold_first, t_hold_last;
    logic [7:0] prev_cnt;
    logic [7:0] exp_cnt;

    task automatic clear_log();
        n_short = 0; n_long = 0; n_double = 0; n_multi = 0; n_cnt_err = 0;
        t_short_first = -1; t_short_last = -1; t_long_first = -1; t_long_last = -1;
        t_double = -1; t_hold_first = -1; t_hold_last = -1;
    endtask

    // Apply inputs for the current cycle, clock once, then log what the outputs show.
    task automatic drive(input logic l, input logic t);
        db_level_in = l;
        db_tick_in  = t;
        prev_cnt    = event_count;
        @(posedge clk_amisha);
        #1;
        cyc++;
        if (short_tick) begin
            n_short++;
            if (t_short_first < 0) t_short_first = cyc;
            t_short_last = cyc;
        end
        if (long_tick) begin
            n_long++;
            if (t_long_first < 0) t_long_first = cyc;
            t_long_last = cyc;
        end
        if (double_tick) begin
            n_double++;
            t_double = cyc;
        end
        if (hold_level) begin
            if (t_hold_first < 0) t_hold_first = cyc;
            t_hold_last = cyc;
        end
        if ((32'(short_tick) + 32'(long_tick) + 32'(double_tick)) > 1) n_multi++;
        exp_cnt = prev_cnt + ((short_tick | long_tick | double_tick) ? 8'd1 : 8'd0);
        if (event_count !== exp_cnt) n_cnt_err++;
    endtask

    task automatic do_reset();
        reset_amisha = 1'b1;
        db_level_in  = 1'b0;
        db_tick_in   = 1'b0;
        @(posedge clk_amisha);
        #1;
        reset_amisha = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        db_level_in  = 1'b0;
        db_tick_in   = 1'b0;
        reset_amisha = 1'b1;
        #1;
        compared++;
        if ({short_tick, long_tick, double_tick, hold_level} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_pulses: got %b expected 0000", {short_tick, long_tick, double_tick, hold_level});
        end
        compared++;
        if (event_count !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_count: got %0d expected 0", event_count);
        end
        @(posedge clk_amisha);
        #1;
        reset_amisha = 1'b0;
        clear_log();
        repeat (5) drive(1'b1, 1'b0);
        compared++;
        if (n_short + n_long + n_double !== 0) begin
            mismatched++;
            $display("FAIL level_alone: got %0d pulses expected 0", n_short + n_long + n_double);
        end
    endtask

    task automatic test_short();
        int t0;
        do_reset();
        t0 = cyc;
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0);
        compared++;
        if (n_short !== 1 || t_short_first !== t0 + 10) begin
            mismatched++;
            $display("FAIL short_timing: got n=%0d at %0d expected n=1 at %0d", n_short, t_short_first - t0, 10);
        end
        compared++;
        if (n_long + n_double !== 0 || event_count !== 8'd1) begin
            mismatched++;
            $display("FAIL short_other: got other=%0d count=%0d expected other=0 count=1", n_long + n_double, event_count);
        end
    endtask

    task automatic test_long();
        int t0;
        do_reset();
        t0 = cyc;
        drive(1'b1, 1'b1);
        repeat (19) drive(1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0);
        compared++;
        if (t_long_first !== t0 + 9) begin
            mismatched++;
            $display("FAIL long_first: got %0d expected 9", t_long_first - t0);
        end
        compared++;
        if (t_hold_first !== t0 + 9 || t_hold_last !== t0 + 20) begin
            mismatched++;
            $display("FAIL hold_window: got %0d..%0d expected 9..20", t_hold_first - t0, t_hold_last - t0);
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        compared++;
        if (n_long !== 3 || t_long_last !== t0 + 17 || event_count !== 8'd3) begin
            mismatched++;
            $display("FAIL long_repeat: got n=%0d last=%0d count=%0d expected n=3 last=17 count=3",
                     n_long, t_long_last - t0, event_count);
        end
`else
        compared++;
        if (n_long !== 1 || event_count !== 8'd1) begin
            mismatched++;
            $display("FAIL long_single: got n=%0d count=%0d expected n=1 count=1", n_long, event_count);
        end
`endif
        compared++;
        if (n_short + n_double !== 0 || n_cnt_err !== 0 || n_multi !== 0) begin
            mismatched++;
            $display("FAIL long_other: got other=%0d cnt_err=%0d multi=%0d expected 0 0 0", n_short + n_double, n_cnt_err, n_multi);
        end
    endtask

    task automatic test_double();
        int t0;
        do_reset();
        t0 = cyc;
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0);
        compared++;
        if (n_double !== 1 || t_double !== t0 + 8) begin
            mismatched++;
            $display("FAIL double_timing: got n=%0d at %0d expected n=1 at 8", n_double, t_double - t0);
        end
        compared++;
        if (n_short + n_long !== 0 || event_count !== 8'd1) begin
            mismatched++;
            $display("FAIL double_other: got other=%0d count=%0d expected other=0 count=1", n_short + n_long, event_count);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        t0 = cyc;
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0);
        compared++;
        if (n_double !== 1 || t_double !== t0 + 8) begin
            mismatched++;
            $display("FAIL b2b_double: got n=%0d at %0d expected n=1 at 8", n_double, t_double - t0);
        end
        compared++;
        if (n_short !== 1 || t_short_first !== t0 + 19 || event_count !== 8'd2) begin
            mismatched++;
            $display("FAIL b2b_short: got n=%0d at %0d count=%0d expected n=1 at 19 count=2",
                     n_short, t_short_first - t0, event_count);
        end
    endtask

    task automatic test_gap_boundary();
        int t0;
        do_reset();
        t0 = cyc;
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (6) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0);
        compared++;
        if (n_double !== 1 || t_double !== t0 + 12 || n_short !== 0) begin
            mismatched++;
            $display("FAIL gap_last_cycle: got double=%0d at %0d short=%0d expected 1 at 12 short=0",
                     n_double, t_double - t0, n_short);
        end

        do_reset();
        t0 = cyc;
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (7) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (12) drive(1'b0, 1'b0);
        compared++;
        if (n_short !== 2 || t_short_first !== t0 + 10 || t_short_last !== t0 + 20) begin
            mismatched++;
            $display("FAIL gap_expired: got n=%0d at %0d,%0d expected n=2 at 10,20",
                     n_short, t_short_first - t0, t_short_last - t0);
        end
        compared++;
        if (n_double !== 0 || event_count !== 8'd2) begin
            mismatched++;
            $display("FAIL gap_expired_other: got double=%0d count=%0d expected 0 and 2", n_double, event_count);
        end
    endtask

    task automatic test_reset_mid();
        // PRESSED, with event_count still nonzero from the previous test
        clear_log();
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        #2;
        reset_amisha = 1'b1;
        #1;
        compared++;
        if ({short_tick, long_tick, double_tick, hold_level, event_count} !== 12'b0) begin
            mismatched++;
            $display("FAIL reset_mid_pressed: got %h expected 000", {short_tick, long_tick, double_tick, hold_level, event_count});
        end
        @(posedge clk_amisha);
        #1;
        reset_amisha = 1'b0;
        clear_log();
        repeat (12) drive(1'b1, 1'b0);
        repeat (12) drive(1'b0, 1'b0);
        compared++;
        if (n_short + n_long + n_double !== 0 || event_count !== 8'd0) begin
            mismatched++;
            $display("FAIL after_reset_pressed: got pulses=%0d count=%0d expected 0 0", n_short + n_long + n_double, event_count);
        end

        // WAIT_GAP
        drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        #2;
        reset_amisha = 1'b1;
        #1;
        compared++;
        if ({short_tick, long_tick, double_tick, hold_level, event_count} !== 12'b0) begin
            mismatched++;
            $display("FAIL reset_mid_gap: got %h expected 000", {short_tick, long_tick, double_tick, hold_level, event_count});
        end
        @(posedge clk_amisha);
        #1;
        reset_amisha = 1'b0;
        clear_log();
        repeat (15) drive(1'b0, 1'b0);
        compared++;
        if (n_short + n_long + n_double !== 0 || event_count !== 8'd0) begin
            mismatched++;
            $display("FAIL after_reset_gap: got pulses=%0d count=%0d expected 0 0", n_short + n_long + n_double, event_count);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1);
            drive(1'b1, 1'b0);
            repeat (9) drive(1'b0, 1'b0);
            if (i == 254) begin
                compared++;
                if (event_count !== 8'd255) begin
                    mismatched++;
                    $display("FAIL count_255: got %0d expected 255", event_count);
                end
            end
        end
        compared++;
        if (event_count !== 8'd0 || n_short !== 256) begin
            mismatched++;
            $display("FAIL count_wrap: got count=%0d shorts=%0d expected 0 and 256", event_count, n_short);
        end
        compared++;
        if (n_cnt_err !== 0 || n_multi !== 0) begin
            mismatched++;
            $display("FAIL count_step: got cnt_err=%0d multi=%0d expected 0 0", n_cnt_err, n_multi);
        end
    endtask

    initial begin
        reset_amisha = 1'b0;
        db_level_in  = 1'b0;
        db_tick_in   = 1'b0;
        clear_log();
        #2;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_back_to_back();
        test_gap_boundary();
        test_reset_mid();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
